lsu_ecc_scrub: RTL and testbench
================================

# lsu_ecc_scrub

DCCM single-bit-error scrub queue, downstream of the LSU ECC check stage in DC3. On a load that reads a correctable error, it captures the corrected word and its word address, queues it, and writes it back to DCCM through a request/grant handshake on the DCCM write-port arbiter. Check bits come from an internal `rvecc_encode` instance. Double-bit errors are never scrubbed. Queued entries are invalidated if a store-buffer write to the same word reaches DCCM first.

## Interface
- `DCCM_BITS`, 16, DCCM byte-address width.
- `DATA_WIDTH`, 32, DCCM bank word width.
- `ECC_WIDTH`, 7, check bits per word.
- `DEPTH`, 4, queue entries (power of 2, ≥2).

Reset: one clock; reset is asynchronous and active-low (`clk`, `rst_l`).

- `clk` in 1: core clock.
- `rst_l` in 1: async active-low reset.
- `ecc_capture_en_dc3` in 1: valid, unflushed DCCM load in DC3 with ECC enabled.
- `single_ecc_error_lo_dc3` in 1: correctable error, lo bank.
- `single_ecc_error_hi_dc3` in 1: correctable error, hi bank.
- `lsu_double_ecc_error_dc3` in 1: uncorrectable error on either bank.
- `lsu_addr_dc3` in DCCM_BITS: start address (lo word).
- `end_addr_dc3` in DCCM_BITS: end address (hi word).
- `store_ecc_datafn_lo_dc3` in DATA_WIDTH: corrected lo word.
- `store_ecc_datafn_hi_dc3` in DATA_WIDTH: corrected hi word.
- `stbuf_dccm_wr_en` in 1: store buffer writing DCCM this cycle.
- `stbuf_dccm_wr_addr` in DCCM_BITS: that write's address.
- `scrub_wr_gnt` in 1: arbiter grants the DCCM write port.
- `scrub_wr_req` out 1: scrub write request.
- `scrub_wr_addr` out DCCM_BITS: word-aligned address (`[1:0]`=0).
- `scrub_wr_data` out DATA_WIDTH: corrected data.
- `scrub_wr_ecc` out ECC_WIDTH: `rvecc_encode(scrub_wr_data)`.
- `scrub_empty` out 1: no valid entries.
- `scrub_overflow` out 1: one-cycle pulse when a capture is dropped.
- `scrub_done_cnt` out 16: completed scrubs, saturating at 0xFFFF.

## Operation
- **Capture gating.** Capture occurs when `ecc_capture_en_dc3 & ~lsu_double_ecc_error_dc3`.
- **Pushes per capture.**
  - Lo push if `single_ecc_error_lo_dc3`: address = `{lsu_addr_dc3[DCCM_BITS-1:2],2'b0}`, data = lo data.
  - Hi push if `single_ecc_error_hi_dc3`: address = `{end_addr_dc3[DCCM_BITS-1:2],2'b0}`, data = hi data.
  - When both are pushed, lo is written before hi.
- **Queue.** Circular FIFO: write pointer, read pointer, and a count of width `$clog2(DEPTH)+1`. Each entry holds `{valid, addr, data}`.
- **Overflow.** Pushes beyond free space are dropped. Lo takes priority, then hi. `scrub_overflow` pulses the next cycle if any push was dropped. Free space is evaluated after a same-cycle pop.
- **Duplicate capture.** A new capture whose address matches a valid queued entry still pushes. Correctness is unaffected.
- **Invalidation.** `stbuf_dccm_wr_en` with `stbuf_dccm_wr_addr[DCCM_BITS-1:2]` equal to a valid entry's word address clears that entry's valid bit. This applies to every matching entry, including the head. A same-cycle push to a matching address is not invalidated.
- **State machine.** States IDLE, REQ, POP.
  - IDLE → REQ when count≠0.
  - REQ, head valid: `scrub_wr_req`=1. On `scrub_wr_gnt`: pop, increment `scrub_done_cnt`, go to POP.
  - REQ, head invalid: pop without request and without counting. Stay in REQ if count after pop ≠0, else go to IDLE.
  - POP: `scrub_wr_req`=0 for one cycle. Then REQ if count≠0, else IDLE.
- **Request stability.** While `scrub_wr_req`=1, `addr`/`data`/`ecc` are held stable until grant. If the head is invalidated while requesting, `scrub_wr_req` drops the next cycle with no grant counted.
- **Guaranteed exclusion.** `scrub_wr_gnt` and `stbuf_dccm_wr_en` are never both high; the single write port guarantees this.
- `scrub_empty` = no valid entries (count=0, or all entries invalid).

## Timing
- **Reset.** All of the following are 0: `scrub_wr_req`, `scrub_wr_addr`, `scrub_wr_data`, `scrub_wr_ecc` (encode of registered zero data), `scrub_overflow`, `scrub_done_cnt`, pointers, count, valid bits. `scrub_empty`=1, state IDLE.
- Reset mid-request discards all entries. `scrub_wr_req` falls asynchronously.
- **Latencies.**
  - Capture in cycle N → entry visible at N+1.
  - `scrub_wr_req` earliest at N+2: IDLE→REQ at the N+1 edge, request registered.
  - Grant at M → `scrub_wr_req`=0 at M+1 (POP) → next request at M+2.
- **Throughput.** One scrub per 2 cycles under continuous grant.
- **Simultaneous events.** Push and pop in the same cycle are allowed. With `DEPTH` entries full and a pop that cycle, one push is accepted.

## Test plan
- **Lo-only capture.** Lo single error at addr 0x0106, data 0xDEADBEEF → req at N+2 with addr 0x0104, data 0xDEADBEEF, ecc = encoder value. Grant at N+4 → `scrub_done_cnt`=1, `scrub_empty`=1 at N+5.
- **Dual-bank capture.** `lsu_addr` 0x0006, `end_addr` 0x000A, both single errors → two requests in order 0x0004 then 0x0008, separated by a 1-cycle POP bubble.
- **Double error.** Double error with both single flags set → no push, `scrub_empty` stays 1, `scrub_wr_req` never asserts.
- **Overflow.** Queue at count=3 (DEPTH 4), grant held low, dual capture → lo accepted, hi dropped. `scrub_overflow`=1 for exactly one cycle, count=4.
- **Invalidation while requesting.** Head 0x0010 requesting, no grant, `stbuf_dccm_wr_en` at 0x0012 → req drops next cycle. Entry popped uncounted, next entry requested, `scrub_done_cnt` unchanged.
- **Reset and saturation.** `rst_l` low during REQ → all outputs return to reset values immediately. Separately, preload `scrub_done_cnt`=0xFFFF and complete a scrub → count stays 0xFFFF.

Source files
------------

// File: rtl/lsu_ecc_scrub.sv
// DCCM single-bit-error scrub queue: captures corrected load words from DC3 and
// writes them back with fresh check bits through the DCCM write-port arbiter.

module rvecc_encode (
   input  logic [31:0] din,
   output logic [6:0]  ecc_out
);
   // Codeword indexed by Hamming position; data occupies non-power-of-two slots.
   logic [38:1] cw;
   logic [5:0]  p;

   always_comb begin
      cw        = '0;
      cw[3]     = din[0];
      cw[7:5]   = din[3:1];
      cw[15:9]  = din[10:4];
      cw[31:17] = din[25:11];
      cw[38:33] = din[31:26];
      p         = '0;
      for (int b = 0; b < 6; b++)
         for (int k = 1; k < 39; k++)
            if (k[b]) p[b] = p[b] ^ cw[k];
      ecc_out = {(^din) ^ (^p), p};
   end
endmodule

module lsu_ecc_scrub #(
   parameter int DCCM_BITS  = 16,
   parameter int DATA_WIDTH = 32,
   parameter int ECC_WIDTH  = 7,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_l,
   input  logic                  ecc_capture_en_dc3,
   input  logic                  single_ecc_error_lo_dc3,
   input  logic                  single_ecc_error_hi_dc3,
   input  logic                  lsu_double_ecc_error_dc3,
   input  logic [DCCM_BITS-1:0]  lsu_addr_dc3,
   input  logic [DCCM_BITS-1:0]  end_addr_dc3,
   input  logic [DATA_WIDTH-1:0] store_ecc_datafn_lo_dc3,
   input  logic [DATA_WIDTH-1:0] store_ecc_datafn_hi_dc3,
   input  logic                  stbuf_dccm_wr_en,
   input  logic [DCCM_BITS-1:0]  stbuf_dccm_wr_addr,
   input  logic                  scrub_wr_gnt,
   output logic                  scrub_wr_req,
   output logic [DCCM_BITS-1:0]  scrub_wr_addr,
   output logic [DATA_WIDTH-1:0] scrub_wr_data,
   output logic [ECC_WIDTH-1:0]  scrub_wr_ecc,
   output logic                  scrub_empty,
   output logic                  scrub_overflow,
   output logic [15:0]           scrub_done_cnt
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, REQ, POP} state_e;

   state_e                           state_q, state_d;
   logic [DEPTH-1:0]                 vld_q, vld_d;
   logic [DEPTH-1:0][DCCM_BITS-1:0]  addr_q, addr_d;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
   logic [PW-1:0]                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, hi_slot;
   logic [CW-1:0]                    cnt_q, cnt_d, free;
   logic                             ovf_q, ovf_d;
   logic [15:0]                      done_cnt_q, done_cnt_d;
   logic                             capture, lo_req, hi_req, lo_acc, hi_acc;
   logic                             head_vld, pop, done;
   logic [1:0]                       n_push;
   logic [DCCM_BITS-1:0]             lo_addr, hi_addr;
   logic                             unused_lsbs;

   assign unused_lsbs = ^{lsu_addr_dc3[1:0], end_addr_dc3[1:0], stbuf_dccm_wr_addr[1:0]};

   assign capture = ecc_capture_en_dc3 & ~lsu_double_ecc_error_dc3;
   assign lo_req  = capture & single_ecc_error_lo_dc3;
   assign hi_req  = capture & single_ecc_error_hi_dc3;
   assign lo_addr = {lsu_addr_dc3[DCCM_BITS-1:2], 2'b00};
   assign hi_addr = {end_addr_dc3[DCCM_BITS-1:2], 2'b00};

   // An invalidated head is dropped without a request; a valid head waits for grant.
   assign head_vld = vld_q[rd_ptr_q];
   assign pop      = (state_q == REQ) && (cnt_q != '0) && (!head_vld || scrub_wr_gnt);
   assign done     = pop & head_vld;

   // Space freed by this cycle's pop is usable by this cycle's pushes.
   assign free    = CW'(DEPTH) - cnt_q + CW'(pop);
   assign lo_acc  = lo_req && (free != '0);
   assign hi_acc  = hi_req && (free > CW'(lo_acc));
   assign hi_slot = lo_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
   assign n_push  = {1'b0, lo_acc} + {1'b0, hi_acc};

   assign cnt_d      = cnt_q + CW'(n_push) - CW'(pop);
   assign wr_ptr_d   = wr_ptr_q + PW'(n_push);
   assign rd_ptr_d   = rd_ptr_q + PW'(pop);
   assign ovf_d      = (lo_req & ~lo_acc) | (hi_req & ~hi_acc);
   assign done_cnt_d = (done && done_cnt_q != 16'hFFFF) ? done_cnt_q + 16'd1 : done_cnt_q;

   // Order matters: invalidate, then pop, then push, so a fresh push always survives.
   always_comb begin
      vld_d  = vld_q;
      addr_d = addr_q;
      data_d = data_q;
      for (int i = 0; i < DEPTH; i++)
         if (stbuf_dccm_wr_en && addr_q[i][DCCM_BITS-1:2] == stbuf_dccm_wr_addr[DCCM_BITS-1:2])
            vld_d[i] = 1'b0;
      if (pop) vld_d[rd_ptr_q] = 1'b0;
      if (lo_acc) begin
         vld_d[wr_ptr_q]  = 1'b1;
         addr_d[wr_ptr_q] = lo_addr;
         data_d[wr_ptr_q] = store_ecc_datafn_lo_dc3;
      end
      if (hi_acc) begin
         vld_d[hi_slot]  = 1'b1;
         addr_d[hi_slot] = hi_addr;
         data_d[hi_slot] = store_ecc_datafn_hi_dc3;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cnt_q != '0) state_d = REQ;
         REQ:     if (done) state_d = POP;
                  else if (cnt_d == '0) state_d = IDLE;
         POP:     state_d = (cnt_q != '0) ? REQ : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q    <= IDLE;
         vld_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         done_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         vld_q      <= vld_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         done_cnt_q <= done_cnt_d;
      end
   end

   // Head slot is only rewritten after it is popped, so these hold until grant.
   assign scrub_wr_req   = (state_q == REQ) && (cnt_q != '0) && head_vld;
   assign scrub_wr_addr  = addr_q[rd_ptr_q];
   assign scrub_wr_data  = data_q[rd_ptr_q];
   assign scrub_empty    = ~|vld_q;
   assign scrub_overflow = ovf_q;
   assign scrub_done_cnt = done_cnt_q;

   rvecc_encode u_ecc (
      .din     (scrub_wr_data),
      .ecc_out (scrub_wr_ecc)
   );
endmodule

// File: tb/tb_lsu_ecc_scrub.sv
// Scoreboard bench for lsu_ecc_scrub: expected write-backs queued at capture time,
// a negedge monitor compares every granted scrub write against the queue front.

module tb_lsu_ecc_scrub;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_l = 1'b0;
   logic        ecc_capture_en_dc3, single_ecc_error_lo_dc3, single_ecc_error_hi_dc3;
   logic        lsu_double_ecc_error_dc3, stbuf_dccm_wr_en, scrub_wr_gnt;
   logic [15:0] lsu_addr_dc3, end_addr_dc3, stbuf_dccm_wr_addr;
   logic [31:0] store_ecc_datafn_lo_dc3, store_ecc_datafn_hi_dc3;
   logic        scrub_wr_req, scrub_empty, scrub_overflow;
   logic [15:0] scrub_wr_addr, scrub_done_cnt;
   logic [31:0] scrub_wr_data;
   logic [6:0]  scrub_wr_ecc;

   always #5 clk = ~clk;

   lsu_ecc_scrub #(.DCCM_BITS(16), .DATA_WIDTH(32), .ECC_WIDTH(7), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_l(rst_l),
      .ecc_capture_en_dc3(ecc_capture_en_dc3),
      .single_ecc_error_lo_dc3(single_ecc_error_lo_dc3),
      .single_ecc_error_hi_dc3(single_ecc_error_hi_dc3),
      .lsu_double_ecc_error_dc3(lsu_double_ecc_error_dc3),
      .lsu_addr_dc3(lsu_addr_dc3), .end_addr_dc3(end_addr_dc3),
      .store_ecc_datafn_lo_dc3(store_ecc_datafn_lo_dc3),
      .store_ecc_datafn_hi_dc3(store_ecc_datafn_hi_dc3),
      .stbuf_dccm_wr_en(stbuf_dccm_wr_en), .stbuf_dccm_wr_addr(stbuf_dccm_wr_addr),
      .scrub_wr_gnt(scrub_wr_gnt), .scrub_wr_req(scrub_wr_req),
      .scrub_wr_addr(scrub_wr_addr), .scrub_wr_data(scrub_wr_data),
      .scrub_wr_ecc(scrub_wr_ecc), .scrub_empty(scrub_empty),
      .scrub_overflow(scrub_overflow), .scrub_done_cnt(scrub_done_cnt)
   );

   typedef struct packed { logic [15:0] addr; logic [31:0] data; } exp_t;
   exp_t        exp_q[$];
   int          errors = 0, checks = 0, ovf_seen = 0, ovf_exp = 0, gnt_mode = 0;
   logic [15:0] exp_done = 16'd0, d0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   // Hamming(38,32) check bits: syndrome is the XOR of the positions of set data bits.
   function automatic logic [6:0] ecc_ref(input logic [31:0] d);
      int pos = 1;
      logic [5:0] syn = '0;
      for (int i = 0; i < 32; i++) begin
         pos++;
         while ((pos & (pos - 1)) == 0) pos++;
         if (d[i]) syn ^= pos[5:0];
      end
      return {(^d) ^ (^syn), syn};
   endfunction

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_l) begin
         if (scrub_overflow) ovf_seen++;
         if (scrub_wr_req && scrub_wr_gnt) begin
            if (exp_q.size() == 0) chk("unexpected_write", 64'(scrub_wr_addr), 64'hFFFF_FFFF);
            else begin
               e = exp_q.pop_front();
               chk("wr_addr", 64'(scrub_wr_addr), 64'(e.addr));
               chk("wr_data", 64'(scrub_wr_data), 64'(e.data));
               chk("wr_ecc", 64'(scrub_wr_ecc), 64'(ecc_ref(e.data)));
               chk("done_cnt", 64'(scrub_done_cnt), 64'(exp_done));
               if (exp_done != 16'hFFFF) exp_done = exp_done + 16'd1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
      ecc_capture_en_dc3 = 0; single_ecc_error_lo_dc3 = 0; single_ecc_error_hi_dc3 = 0;
      lsu_double_ecc_error_dc3 = 0; stbuf_dccm_wr_en = 0;
      case (gnt_mode)
         0:       scrub_wr_gnt = 1'b0;
         1:       scrub_wr_gnt = 1'b1;
         default: scrub_wr_gnt = 1'($urandom_range(0, 1));
      endcase
   endtask

   // room = pushes the queue can still take this cycle; lo is served before hi.
   task automatic capture(input bit en, lo, hi, dbl, input logic [15:0] la, ea,
                          input logic [31:0] dl, dh, input int room);
      int r = room;
      bit drop = 0;
      exp_t e;
      ecc_capture_en_dc3 = en; single_ecc_error_lo_dc3 = lo; single_ecc_error_hi_dc3 = hi;
      lsu_double_ecc_error_dc3 = dbl; lsu_addr_dc3 = la; end_addr_dc3 = ea;
      store_ecc_datafn_lo_dc3 = dl; store_ecc_datafn_hi_dc3 = dh;
      if (en && !dbl) begin
         if (lo) begin
            if (r > 0) begin e.addr = {la[15:2], 2'b00}; e.data = dl; exp_q.push_back(e); r--; end
            else drop = 1;
         end
         if (hi) begin
            if (r > 0) begin e.addr = {ea[15:2], 2'b00}; e.data = dh; exp_q.push_back(e); r--; end
            else drop = 1;
         end
      end
      if (drop) ovf_exp++;
   endtask

   task automatic inval(input logic [15:0] a);
      stbuf_dccm_wr_en = 1; stbuf_dccm_wr_addr = a; scrub_wr_gnt = 0;
      for (int i = exp_q.size() - 1; i >= 0; i--)
         if (exp_q[i].addr[15:2] == a[15:2]) exp_q.delete(i);
   endtask

   task automatic drain(input string name);
      int n = 0;
      gnt_mode = 1;
      while (exp_q.size() != 0 && n < 200) begin step(); n++; end
      chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
      repeat (6) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      ecc_capture_en_dc3 = 0; single_ecc_error_lo_dc3 = 0; single_ecc_error_hi_dc3 = 0;
      lsu_double_ecc_error_dc3 = 0; stbuf_dccm_wr_en = 0; scrub_wr_gnt = 0;
      lsu_addr_dc3 = 0; end_addr_dc3 = 0; stbuf_dccm_wr_addr = 0;
      store_ecc_datafn_lo_dc3 = 0; store_ecc_datafn_hi_dc3 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 64'(scrub_wr_req), 0);   chk("rst_addr", 64'(scrub_wr_addr), 0);
      chk("rst_data", 64'(scrub_wr_data), 0); chk("rst_ecc", 64'(scrub_wr_ecc), 0);
      chk("rst_empty", 64'(scrub_empty), 1);  chk("rst_ovf", 64'(scrub_overflow), 0);
      chk("rst_done", 64'(scrub_done_cnt), 0);
      rst_l = 1;

      // Lo-only capture, grant held off until N+4
      gnt_mode = 0; step();
      capture(1, 1, 0, 0, 16'h0106, 16'h010A, 32'hDEADBEEF, 32'h0, 2);
      step(); @(negedge clk); chk("lo_req_n1", 64'(scrub_wr_req), 0);
      step(); @(negedge clk); chk("lo_req_n2", 64'(scrub_wr_req), 1);
      chk("lo_addr_n2", 64'(scrub_wr_addr), 64'h0104);
      chk("lo_data_n2", 64'(scrub_wr_data), 64'hDEADBEEF);
      chk("lo_ecc_n2", 64'(scrub_wr_ecc), 64'(ecc_ref(32'hDEADBEEF)));
      step(); @(negedge clk); chk("lo_req_n3", 64'(scrub_wr_req), 1);
      gnt_mode = 1; step(); gnt_mode = 0;
      step(); @(negedge clk);
      chk("lo_done_n5", 64'(scrub_done_cnt), 1); chk("lo_empty_n5", 64'(scrub_empty), 1);
      chk("lo_req_n5", 64'(scrub_wr_req), 0);

      // Dual-bank capture under continuous grant: lo, bubble, hi
      repeat (2) step();
      gnt_mode = 1; step();
      capture(1, 1, 1, 0, 16'h0006, 16'h000A, 32'h11112222, 32'h33334444, 2);
      step(); @(negedge clk); chk("dual_req_n1", 64'(scrub_wr_req), 0);
      step(); @(negedge clk); chk("dual_req_n2", 64'(scrub_wr_req), 1);
      chk("dual_addr_n2", 64'(scrub_wr_addr), 64'h0004);
      step(); @(negedge clk); chk("dual_bubble_n3", 64'(scrub_wr_req), 0);
      step(); @(negedge clk); chk("dual_req_n4", 64'(scrub_wr_req), 1);
      chk("dual_addr_n4", 64'(scrub_wr_addr), 64'h0008);
      drain("dual");

      // Double error suppresses both single flags
      capture(1, 1, 1, 1, 16'h0200, 16'h0204, $urandom, $urandom, 2);
      for (int i = 0; i < 4; i++) begin
         step(); @(negedge clk);
         chk("dbl_empty", 64'(scrub_empty), 1); chk("dbl_req", 64'(scrub_wr_req), 0);
      end

      // Overflow with grant held low
      gnt_mode = 0; step();
      capture(1, 1, 0, 0, 16'h0300, 16'h0304, 32'hA0A0A0A0, 32'h0, 2); step();
      capture(1, 1, 1, 0, 16'h0310, 16'h0314, 32'hB1B1B1B1, 32'hB2B2B2B2, 2); step();
      capture(1, 1, 1, 0, 16'h0320, 16'h0324, 32'hC1C1C1C1, 32'hC2C2C2C2, 1);
      @(negedge clk); chk("ovf_n0", 64'(scrub_overflow), 0);
      step(); @(negedge clk); chk("ovf_n1", 64'(scrub_overflow), 1);
      chk("ovf_empty", 64'(scrub_empty), 0);
      step(); @(negedge clk); chk("ovf_n2", 64'(scrub_overflow), 0);
      step(); capture(1, 1, 0, 0, 16'h0330, 16'h0334, 32'hD0D0D0D0, 32'h0, 0);
      step(); @(negedge clk); chk("ovf_full", 64'(scrub_overflow), 1);
      step(); @(negedge clk); chk("ovf_full_clr", 64'(scrub_overflow), 0);
      drain("ovf");

      // Invalidate the requesting head; a same-cycle push to that word survives
      d0 = exp_done;
      gnt_mode = 0; step();
      capture(1, 1, 0, 0, 16'h0010, 16'h0014, 32'h0D100D10, 32'h0, 2); step();
      capture(1, 1, 0, 0, 16'h0020, 16'h0024, 32'h0D200D20, 32'h0, 2); step();
      @(negedge clk); chk("inv_req_pre", 64'(scrub_wr_req), 1);
      chk("inv_addr_pre", 64'(scrub_wr_addr), 64'h0010);
      step();
      inval(16'h0012);
      capture(1, 1, 0, 0, 16'h0012, 16'h0016, 32'h0D300D30, 32'h0, 2);
      step(); @(negedge clk); chk("inv_req_drop", 64'(scrub_wr_req), 0);
      chk("inv_done_same", 64'(scrub_done_cnt), 64'(d0));
      step(); @(negedge clk); chk("inv_next_req", 64'(scrub_wr_req), 1);
      chk("inv_next_addr", 64'(scrub_wr_addr), 64'h0020);
      drain("inv");
      chk("inv_done_after", 64'(scrub_done_cnt), 64'(d0 + 16'd2));

      // Randomized traffic; store-buffer writes kept in a disjoint address half
      gnt_mode = 2;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 4) == 0) inval(16'h8000 | 16'($urandom));
         if (exp_q.size() <= DEPTH - 2 && $urandom_range(0, 2) == 0) begin
            logic [15:0] la;
            la = 16'($urandom) & 16'h7FFF;
            capture($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 5) == 0, la, (la + 16'd4) & 16'h7FFF,
                    $urandom, $urandom, 2);
         end
         step();
      end
      drain("rand");

      // Reset mid-request
      gnt_mode = 0; step();
      capture(1, 1, 0, 0, 16'h0030, 16'h0034, 32'h5A5A5A5A, 32'h0, 2);
      step(); step(); @(negedge clk); chk("mrst_req_pre", 64'(scrub_wr_req), 1);
      #2 rst_l = 0;
      #1;
      chk("mrst_req", 64'(scrub_wr_req), 0);   chk("mrst_addr", 64'(scrub_wr_addr), 0);
      chk("mrst_data", 64'(scrub_wr_data), 0); chk("mrst_ecc", 64'(scrub_wr_ecc), 0);
      chk("mrst_empty", 64'(scrub_empty), 1);  chk("mrst_done", 64'(scrub_done_cnt), 0);
      chk("mrst_ovf", 64'(scrub_overflow), 0);
      exp_q.delete(); exp_done = 16'd0;
      step(); rst_l = 1;
      repeat (2) step();
      @(negedge clk); chk("mrst_stays_empty", 64'(scrub_empty), 1);
      chk("mrst_stays_idle", 64'(scrub_wr_req), 0);

      // Done counter saturation
      force dut.done_cnt_q = 16'hFFFE;
      step();
      release dut.done_cnt_q;
      exp_done = 16'hFFFE;
      @(negedge clk); chk("sat_preload", 64'(scrub_done_cnt), 64'hFFFE);
      gnt_mode = 1; step();
      capture(1, 1, 0, 0, 16'h0040, 16'h0044, 32'h4040_4040, 32'h0, 2); step();
      capture(1, 1, 0, 0, 16'h0050, 16'h0054, 32'h5050_5050, 32'h0, 2); step();
      drain("sat");
      chk("sat_hold", 64'(scrub_done_cnt), 64'hFFFF);

      chk("ovf_pulses", 64'(ovf_seen), 64'(ovf_exp));
      chk("final_empty", 64'(scrub_empty), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
